// File: rtl/barrel_shifter.sv
// Registered rotate unit: a logarithmic barrel of power-of-two rotate stages
// feeding a single output register, giving one result per clock at 1-cycle latency.
module barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_reg,
  input  logic [SHW-1:0]   shift_amt,
  input  logic             in_m,
  output logic [WIDTH-1:0] o_reg,
  output logic             o_valid
);

  localparam int LG = $clog2(WIDTH);

  logic [LG-1:0]          k_s;
  logic [LG-1:0]          amt_s;
  logic [LG:0][WIDTH-1:0] stage_s;
  logic [WIDTH-1:0]       o_reg_d, o_reg_q;
  logic                   o_valid_d, o_valid_q;

  // Left rotate by k is a right rotate by (WIDTH-k) mod WIDTH, which is the
  // two's complement of k truncated to LG bits.
  assign k_s        = shift_amt[LG-1:0];
  assign amt_s      = in_m ? k_s : ({LG{1'b0}} - k_s);
  assign stage_s[0] = in_reg;

  for (genvar s = 0; s < LG; s++) begin : g_stage
    localparam int N = 1 << s;
    assign stage_s[s+1] = amt_s[s] ? {stage_s[s][N-1:0], stage_s[s][WIDTH-1:N]}
                                   : stage_s[s];
  end

  // Next-state: capture a new result on in_valid, otherwise hold data and drop valid.
  always_comb begin
    o_reg_d   = o_reg_q;
    o_valid_d = 1'b0;
    if (in_valid) begin
      o_reg_d   = stage_s[LG];
      o_valid_d = 1'b1;
    end else begin
      o_reg_d   = o_reg_q;
      o_valid_d = 1'b0;
    end
  end

  // Output register with synchronous active-low reset taking priority over capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_reg_q   <= {WIDTH{1'b0}};
      o_valid_q <= 1'b0;
    end else begin
      o_reg_q   <= o_reg_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_reg   = o_reg_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed sweeps, boundary amounts,
// hold behaviour and randomized back-to-back traffic against an index-based model.
module tb_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_reg;
  logic [5:0]  shift_amt;
  logic        in_m;
  logic [31:0] o_reg;
  logic        o_valid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  barrel_shifter #(.WIDTH(32), .SHW(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_reg    (in_reg),
    .shift_amt (shift_amt),
    .in_m      (in_m),
    .o_reg     (o_reg),
    .o_valid   (o_valid)
  );

  // Reference: output bit i takes input bit (i+k) mod 32 for right, (i-k) mod 32 for left.
  function automatic logic [31:0] ref_rot(input logic [31:0] d, input int amt, input bit right);
    logic [31:0] r;
    int k;
    k = amt % 32;
    for (int i = 0; i < 32; i++) begin
      if (right) r[i] = d[(i + k) % 32];
      else       r[i] = d[(i - k + 32) % 32];
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Present one input for one edge and sample #1 after it.
  task automatic apply(input logic v, input logic [31:0] d, input logic [5:0] amt, input logic m);
    in_valid  = v;
    in_reg    = d;
    shift_amt = amt;
    in_m      = m;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_chk(input string tag, input logic [31:0] d, input logic [5:0] amt,
                           input logic m, input logic [31:0] exp);
    apply(1'b1, d, amt, m);
    check_eq(tag, o_reg, exp);
    check_eq({tag, "_vld"}, {31'd0, o_valid}, 32'd1);
  endtask

  logic [31:0] rsweep [5] = '{32'hE9B049D6, 32'h74D824EB, 32'hDD36093A, 32'hADD36093, 32'h93ADD360};
  logic [31:0] lsweep [5] = '{32'hA6C1275B, 32'h4D824EB7, 32'h36093ADD, 32'h6093ADD3, 32'h93ADD360};

  initial begin
    logic [31:0] held, d, exp, first;
    logic [5:0]  amt;
    logic        m;

    rst_n = 1'b0;
    in_valid = 1'b0; in_reg = 32'd0; shift_amt = 6'd0; in_m = 1'b0;

    // Reset dominates a valid input.
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 32'hFFFFFFFF, 6'd0, 1'b1);
      check_eq("rst_data", o_reg, 32'h00000000);
      check_eq("rst_vld", {31'd0, o_valid}, 32'd0);
    end
    rst_n = 1'b1;
    apply_chk("post_rst", 32'hFFFFFFFF, 6'd0, 1'b1, 32'hFFFFFFFF);

    for (int i = 0; i < 5; i++)
      apply_chk($sformatf("rr_k%0d", 1 << i), 32'hD36093AD, 6'(1 << i), 1'b1, rsweep[i]);
    for (int i = 0; i < 5; i++)
      apply_chk($sformatf("rl_k%0d", 1 << i), 32'hD36093AD, 6'(1 << i), 1'b0, lsweep[i]);

    apply_chk("k0_r",    32'h80000001, 6'd0,  1'b1, 32'h80000001);
    apply_chk("k0_l",    32'h80000001, 6'd0,  1'b0, 32'h80000001);
    apply_chk("amt32_r", 32'h80000001, 6'd32, 1'b1, 32'h80000001);
    apply_chk("amt32_l", 32'h80000001, 6'd32, 1'b0, 32'h80000001);
    apply_chk("amt33_r", 32'h80000001, 6'd33, 1'b1, 32'hC0000000);
    apply_chk("amt63_l", 32'h80000001, 6'd63, 1'b0, 32'hC0000000);
    apply_chk("k31_r",   32'h80000001, 6'd31, 1'b1, 32'h00000003);

    // Hold: idle inputs must not disturb the registered result.
    apply_chk("hold_src", 32'h12345678, 6'd4, 1'b1, 32'h81234567);
    held = 32'h81234567;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, $urandom, 6'($urandom), 1'($urandom));
      check_eq("hold_data", o_reg, held);
      check_eq("hold_vld", {31'd0, o_valid}, 32'd0);
    end

    // Random back-to-back traffic.
    for (int n = 0; n < 1000; n++) begin
      d   = $urandom;
      amt = 6'($urandom);
      m   = 1'($urandom);
      exp = ref_rot(d, int'(amt), m);
      apply_chk("rand", d, amt, m, exp);
      check_eq("popcnt", 32'($countones(o_reg)), 32'($countones(d)));
      if (n % 5 == 0) begin
        first = o_reg;
        apply_chk("dual_l", d, 6'(32 - int'(amt % 32)), ~m, exp);
        check_eq("dual_eq", o_reg, first);
      end
    end

    // Half-width rotate is direction-independent.
    d = $urandom;
    apply_chk("half_r", d, 6'd16, 1'b1, {d[15:0], d[31:16]});
    first = o_reg;
    apply_chk("half_l", d, 6'd16, 1'b0, {d[15:0], d[31:16]});
    check_eq("half_eq", o_reg, first);

    // Reset mid-stream discards the result captured on the reset edge.
    rst_n = 1'b0;
    apply(1'b1, 32'hA5A5A5A5, 6'd3, 1'b1);
    check_eq("mid_rst_data", o_reg, 32'h00000000);
    check_eq("mid_rst_vld", {31'd0, o_valid}, 32'd0);
    rst_n = 1'b1;
    apply(1'b0, 32'd0, 6'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
